// File: rtl/small_env_meter_pkg.sv
// Shared definitions for the small-filter family: meter state encoding and a
// saturating signed-magnitude helper usable by any block on the filter path.
package small_env_meter_pkg;

  // One-bit state encoding for the envelope meter.
  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_ACCUM  = 1'b1
  } meter_state_t;

  // Saturating |x| for a signed value of the given width (1..32), carried in a
  // 32-bit sign-extended container. The most negative value maps to the most
  // positive one, so the result always fits in width-1 bits.
  function automatic logic [31:0] abs_sat(input logic signed [31:0] x,
                                          input int unsigned width);
    logic signed [31:0] most_neg;
    most_neg = -(32'sd1 <<< (width - 1));
    if (x == most_neg) begin
      return (32'd1 << (width - 1)) - 32'd1;
    end else if (x < 0) begin
      return $unsigned(-x);
    end else begin
      return $unsigned(x);
    end
  endfunction

endpackage

// File: rtl/small_env_meter_abs_sat.sv
// Combinational saturating magnitude of a signed WIDTH-bit sample.
module small_abs_sat
  import small_env_meter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] mag
);

  assign mag = WIDTH'(abs_sat(32'($signed(x)), WIDTH));

endmodule

// File: rtl/small_env_meter.sv
// Windowed envelope meter: peak and mean magnitude over 2^WIN_SHIFT accepted
// samples, after discarding SETTLE start-up samples, with a valid/ready result
// port and a sticky overrun flag.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_SETTLE | discarding start-up samples, nothing accumulated
//   ST_ACCUM  | accumulating windows, result posted at every window close
module small_env_meter
  import small_env_meter_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int WIN_SHIFT = 10,
  parameter int SETTLE    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] peakOut,
  output logic [WIDTH-1:0] meanOut,
  output logic             outValid,
  input  logic             outReady,
  output logic             overrun
);

  localparam int SUM_W = WIDTH + WIN_SHIFT;
  localparam meter_state_t RESET_STATE = (SETTLE > 0) ? ST_SETTLE : ST_ACCUM;
  localparam logic [15:0] SETTLE_LAST = 16'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [WIN_SHIFT-1:0] CNT_LAST = {WIN_SHIFT{1'b1}};

  meter_state_t         state;
  meter_state_t         next_state;
  logic [WIDTH-1:0]     mag;
  logic [15:0]          settle_cnt;
  logic [WIN_SHIFT-1:0] cnt;
  logic [WIDTH-1:0]     peak_acc;
  logic [SUM_W-1:0]     sum_acc;

  logic                 settle_done;
  logic                 accum_hit;
  logic                 win_close;
  logic [WIDTH-1:0]     peak_next;
  logic [SUM_W-1:0]     sum_next;
  logic [WIDTH-1:0]     mean_next;

  small_abs_sat #(.WIDTH(WIDTH)) u_abs (
    .x   (dataIn),
    .mag (mag)
  );

  // Accumulator values including the sample at this edge; the window result
  // is taken from these so the closing sample is never lost.
  assign peak_next = (mag > peak_acc) ? mag : peak_acc;
  assign sum_next  = sum_acc + SUM_W'(mag);
  assign mean_next = sum_next[WIN_SHIFT +: WIDTH];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RESET_STATE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and per-edge decode of what an accepted sample does.
  always_comb begin
    next_state  = state;
    settle_done = 1'b0;
    accum_hit   = 1'b0;
    win_close   = 1'b0;
    case (state)
      ST_SETTLE: begin
        if (en) begin
          settle_done = (settle_cnt == SETTLE_LAST);
          if (settle_done) begin
            next_state = ST_ACCUM;
          end
        end
      end
      ST_ACCUM: begin
        if (en) begin
          accum_hit = 1'b1;
          win_close = (cnt == CNT_LAST);
        end
      end
    endcase
  end

  // Settle counter: counts discarded start-up samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= '0;
    end else if (settle_done) begin
      settle_cnt <= '0;
    end else if ((state == ST_SETTLE) && en) begin
      settle_cnt <= settle_cnt + 16'd1;
    end
  end

  // Window accumulators; a closing window reloads them as empty so the next
  // window starts cleanly at the following accepted sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      peak_acc <= '0;
      sum_acc  <= '0;
    end else if (accum_hit) begin
      if (win_close) begin
        cnt      <= '0;
        peak_acc <= '0;
        sum_acc  <= '0;
      end else begin
        cnt      <= cnt + WIN_SHIFT'(1);
        peak_acc <= peak_next;
        sum_acc  <= sum_next;
      end
    end
  end

  // Result registers and handshake; a new result always wins over an accept,
  // and overwriting an unaccepted result sets the sticky overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      peakOut  <= '0;
      meanOut  <= '0;
      outValid <= 1'b0;
      overrun  <= 1'b0;
    end else if (win_close) begin
      peakOut  <= peak_next;
      meanOut  <= mean_next;
      outValid <= 1'b1;
      if (outValid && !outReady) begin
        overrun <= 1'b1;
      end
    end else if (outValid && outReady) begin
      outValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_small_env_meter.sv
// Bench for small_env_meter: two instances (SETTLE=0 and SETTLE=8, 16-sample
// windows) checked every cycle against a queue-based window model, plus
// table-driven windows and directed multi-cycle sequences.
module tb_small_env_meter;

  localparam int W   = 16;
  localparam int WS  = 4;
  localparam int ST1 = 8;
  localparam int WIN = 1 << WS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          outReady = 1'b0;
  logic [W-1:0]  dataIn = '0;
  logic [W-1:0]  peak0, mean0, peak1, mean1;
  logic          valid0, ovr0, valid1, ovr1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  small_env_meter #(.WIDTH(W), .WIN_SHIFT(WS), .SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .dataIn(dataIn),
    .peakOut(peak0), .meanOut(mean0), .outValid(valid0),
    .outReady(outReady), .overrun(ovr0)
  );

  small_env_meter #(.WIDTH(W), .WIN_SHIFT(WS), .SETTLE(ST1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .dataIn(dataIn),
    .peakOut(peak1), .meanOut(mean1), .outValid(valid1),
    .outReady(outReady), .overrun(ovr1)
  );

  // Reference model: a queue of magnitudes per instance; a window closes when
  // the queue holds WIN entries.
  int m_q [2][$];
  int m_settle [2];
  int m_valid [2];
  int m_ovr [2];
  int m_peak [2];
  int m_mean [2];

  function automatic int mag_of(input logic [W-1:0] d);
    int v;
    v = int'($signed(d));
    if (v == -32768) return 32767;
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int closed;
      int mx;
      int sm;
      closed = 0;
      mx = 0;
      sm = 0;
      if (rst) begin
        m_q[i].delete();
        m_settle[i] = (i == 0) ? 0 : ST1;
        m_valid[i] = 0;
        m_ovr[i] = 0;
        m_peak[i] = 0;
        m_mean[i] = 0;
      end else begin
        if (en) begin
          if (m_settle[i] > 0) begin
            m_settle[i]--;
          end else begin
            m_q[i].push_back(mag_of(dataIn));
            if (m_q[i].size() == WIN) begin
              for (int k = 0; k < WIN; k++) begin
                if (m_q[i][k] > mx) mx = m_q[i][k];
                sm += m_q[i][k];
              end
              m_q[i].delete();
              closed = 1;
            end
          end
        end
        if (closed != 0) begin
          if (m_valid[i] != 0 && !outReady) m_ovr[i] = 1;
          m_valid[i] = 1;
          m_peak[i] = mx;
          m_mean[i] = sm / WIN;
        end else if (m_valid[i] != 0 && outReady) begin
          m_valid[i] = 0;
        end
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("m0_valid", int'(valid0), m_valid[0]);
    chk("m0_peak",  int'(peak0),  m_peak[0]);
    chk("m0_mean",  int'(mean0),  m_mean[0]);
    chk("m0_ovr",   int'(ovr0),   m_ovr[0]);
    chk("m1_valid", int'(valid1), m_valid[1]);
    chk("m1_peak",  int'(peak1),  m_peak[1]);
    chk("m1_mean",  int'(mean1),  m_mean[1]);
    chk("m1_ovr",   int'(ovr1),   m_ovr[1]);
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, then
  // compare on the falling edge.
  task automatic step(input bit r, input bit e, input logic [W-1:0] d, input bit rdy);
    rst = r;
    en = e;
    dataIn = d;
    outReady = rdy;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_model();
  endtask

  task automatic feed(input int n, input logic [W-1:0] v, input bit rdy);
    for (int k = 0; k < n; k++) step(1'b0, 1'b1, v, rdy);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, '0, 1'b0);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           peak;
    int           mean;
  } vec_t;

  vec_t tbl [7];

  initial begin
    tbl[0] = '{16'd1000,       16'd1000,       1000,  1000};
    tbl[1] = '{16'd3000,       16'(-3000),     3000,  3000};
    tbl[2] = '{16'h8000,       16'h8000,       32767, 32767};
    tbl[3] = '{16'd0,          16'd0,          0,     0};
    tbl[4] = '{16'(-1),        16'd2,          2,     1};
    tbl[5] = '{16'd32767,      16'(-32767),    32767, 32767};
    tbl[6] = '{16'(-5),        16'(-7),        7,     6};

    // Reset state.
    do_reset();
    do_reset();
    chk("rst_peak", int'(peak0), 0);
    chk("rst_mean", int'(mean0), 0);
    chk("rst_valid", int'(valid0), 0);
    chk("rst_ovr", int'(ovr0), 0);

    // Table of alternating-value windows.
    for (int t = 0; t < 7; t++) begin
      do_reset();
      for (int k = 0; k < WIN; k++) begin
        step(1'b0, 1'b1, (k % 2 == 1) ? tbl[t].b : tbl[t].a, 1'b0);
        if (k == WIN - 2) chk("tbl_valid_early", int'(valid0), 0);
      end
      chk("tbl_valid", int'(valid0), 1);
      chk("tbl_peak", int'(peak0), tbl[t].peak);
      chk("tbl_mean", int'(mean0), tbl[t].mean);
      chk("tbl_ovr", int'(ovr0), 0);
    end

    // Fifteen zeros and one most-negative sample.
    do_reset();
    feed(WIN - 1, 16'd0, 1'b0);
    feed(1, 16'h8000, 1'b0);
    chk("sat_peak", int'(peak0), 32767);
    chk("sat_mean", int'(mean0), 2047);

    // Enable on every third cycle; junk presented while disabled.
    do_reset();
    begin
      int idx;
      idx = 1;
      for (int c = 0; c < 3 * WIN; c++) begin
        if (c % 3 == 2) begin
          step(1'b0, 1'b1, 16'(idx), 1'b0);
          idx++;
        end else begin
          step(1'b0, 1'b0, 16'd30000, 1'b0);
        end
        if (c == 3 * WIN - 2) chk("gap_valid_early", int'(valid0), 0);
      end
    end
    chk("gap_valid", int'(valid0), 1);
    chk("gap_peak", int'(peak0), 16);
    chk("gap_mean", int'(mean0), 8);

    // Back-pressure across two windows, then a single accept.
    do_reset();
    feed(WIN, 16'd500, 1'b0);
    chk("bp_first_ovr", int'(ovr0), 0);
    feed(WIN, 16'd700, 1'b0);
    chk("bp_peak", int'(peak0), 700);
    chk("bp_mean", int'(mean0), 700);
    chk("bp_ovr", int'(ovr0), 1);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("bp_acc_valid", int'(valid0), 0);
    chk("bp_acc_ovr", int'(ovr0), 1);
    chk("bp_acc_peak", int'(peak0), 700);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("bp_ovr_sticky", int'(ovr0), 1);

    // Accept on the same edge as a window close.
    do_reset();
    feed(WIN, 16'd300, 1'b0);
    chk("co_valid0", int'(valid0), 1);
    feed(WIN - 1, 16'd400, 1'b0);
    feed(1, 16'd400, 1'b1);
    chk("co_valid", int'(valid0), 1);
    chk("co_peak", int'(peak0), 400);
    chk("co_mean", int'(mean0), 400);
    chk("co_ovr", int'(ovr0), 0);

    // Settling instance discards its first eight samples.
    do_reset();
    feed(ST1, 16'd20000, 1'b0);
    feed(WIN - 1, 16'd100, 1'b0);
    chk("st_valid_early", int'(valid1), 0);
    feed(1, 16'd100, 1'b0);
    chk("st_valid", int'(valid1), 1);
    chk("st_peak", int'(peak1), 100);
    chk("st_mean", int'(mean1), 100);
    chk("st_ovr", int'(ovr1), 0);

    // Reset in mid-window.
    do_reset();
    feed(7, 16'd9000, 1'b0);
    step(1'b1, 1'b1, 16'd9000, 1'b0);
    chk("mr_peak", int'(peak0), 0);
    chk("mr_mean", int'(mean0), 0);
    chk("mr_valid", int'(valid0), 0);
    feed(WIN - 1, 16'd50, 1'b0);
    chk("mr_valid_early", int'(valid0), 0);
    feed(1, 16'd50, 1'b0);
    chk("mr_valid", int'(valid0), 1);
    chk("mr_peak2", int'(peak0), 50);
    chk("mr_mean2", int'(mean0), 50);

    // Randomized traffic checked against the model every cycle.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bit r;
      bit e;
      bit rdy;
      logic [W-1:0] d;
      int sel;
      r = ($urandom_range(0, 599) == 0);
      e = ($urandom_range(0, 3) != 0);
      rdy = (n < 1500) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
      sel = $urandom_range(0, 9);
      case (sel)
        0: d = 16'h8000;
        1: d = 16'h7fff;
        2: d = 16'h8001;
        default: d = 16'($urandom);
      endcase
      step(r, e, d, rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
